// File: rtl/sg_pkg.sv
// Shared constants and state encoding for the data segmenter.
package sg_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 12;
   localparam int DES_W  = 4;
   localparam int PRI_W  = 3;
   localparam int NPORTS = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      HEAD  = 3'd2,
      DATA  = 3'd3,
      DRAIN = 3'd4
   } state_e;

endpackage

// File: rtl/data_sg_if.sv
// Ingress-side packet stream and SRAM write-request bundle of the segmenter.
interface data_sg_if
   import sg_pkg::*;
();

   logic              busy;
   logic              transfering;
   logic [NPORTS-1:0] eop;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] address_in;
   logic [PRI_W-1:0]  priority_in;
   logic [DES_W-1:0]  des_port_in;

   logic              request;
   logic [PRI_W-1:0]  wr_priority;
   logic [DES_W-1:0]  des_port;
   logic [ADDR_W-1:0] address_write;
   logic [DATA_W-1:0] data_write;

   // Segmenter side: consumes the packet stream, produces write requests.
   modport slave (
      input  busy, transfering, eop, data_in, address_in, priority_in, des_port_in,
      output request, wr_priority, des_port, address_write, data_write
   );

   // Ingress / arbiter side.
   modport master (
      output busy, transfering, eop, data_in, address_in, priority_in, des_port_in,
      input  request, wr_priority, des_port, address_write, data_write
   );

endinterface

// File: rtl/data_sg.sv
// Data segmenter: turns a streamed packet into one SRAM write request per
// word, addressed sequentially from a base sampled on the first data word.
module data_sg
   import sg_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   data_sg_if.slave  sg
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [PRI_W-1:0]  pri_q, pri_d;
   logic [DES_W-1:0]  des_q, des_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_s;
   state_e            exit_s;

   // Next state, counters and output-stage values for the coming cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      pri_d   = pri_q;
      des_d   = des_q;
      req_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      last_s  = |sg.eop;
      exit_s  = sg.busy ? ARMED : IDLE;

      case (state_q)
         IDLE: begin
            if (sg.busy) begin
               pri_d   = sg.priority_in;
               state_d = ARMED;
            end else begin
               state_d = IDLE;
            end
         end
         ARMED: begin
            if (sg.transfering) begin
               // header cycle: destination is captured here, data follows
               des_d   = sg.des_port_in;
               state_d = sg.busy ? HEAD : IDLE;
            end else begin
               pri_d   = sg.priority_in;
               state_d = sg.busy ? ARMED : IDLE;
            end
         end
         HEAD: begin
            if (sg.transfering) begin
               // first data word: address_in is the base, word 0 lands on it
               base_d  = sg.address_in;
               req_d   = 1'b1;
               addr_d  = sg.address_in;
               data_d  = sg.data_in;
               idx_d   = 12'd1;
               state_d = last_s ? DRAIN : DATA;
            end else begin
               state_d = exit_s;
            end
         end
         DATA: begin
            if (sg.transfering) begin
               req_d   = 1'b1;
               addr_d  = base_q + idx_q;
               data_d  = sg.data_in;
               idx_d   = idx_q + 12'd1;
               state_d = last_s ? DRAIN : DATA;
            end else begin
               // stream dropped without eop: abandon the packet silently
               state_d = exit_s;
            end
         end
         DRAIN: begin
            if (!sg.transfering) begin
               state_d = exit_s;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= 12'd0;
         base_q  <= 12'd0;
         pri_q   <= 3'd0;
         des_q   <= 4'd0;
         req_q   <= 1'b0;
         addr_q  <= 12'd0;
         data_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         pri_q   <= pri_d;
         des_q   <= des_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign sg.request       = req_q;
   assign sg.wr_priority   = pri_q;
   assign sg.des_port      = des_q;
   assign sg.address_write = addr_q;
   assign sg.data_write    = data_q;

endmodule

// File: tb/tb_data_sg.sv
// Directed bench for data_sg with a write-request scoreboard.
module tb_data_sg;

   typedef struct {
      logic [11:0] a;
      logic [63:0] d;
   } exp_t;

   logic   clk;
   logic   rst;
   int     checks;
   int     errors;
   string  phase;
   exp_t   exp_q[$];

   data_sg_if sg_if ();

   data_sg dut (
      .clk (clk),
      .rst (rst),
      .sg  (sg_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are checked 1 time unit after the edge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("request", {63'd0, sg_if.request}, 64'd1);
         chk("address", {52'd0, sg_if.address_write}, {52'd0, e.a});
         chk("data", sg_if.data_write, e.d);
      end else begin
         chk("no_request", {63'd0, sg_if.request}, 64'd0);
      end
   endtask

   task automatic idle_in(input logic b);
      sg_if.busy        = b;
      sg_if.transfering = 1'b0;
      sg_if.eop         = 16'd0;
   endtask

   task automatic header(input logic [2:0] pri, input logic [3:0] des);
      sg_if.busy        = 1'b1;
      sg_if.transfering = 1'b0;
      sg_if.priority_in = pri;
      step();
      sg_if.transfering = 1'b1;
      sg_if.des_port_in = des;
      sg_if.priority_in = ~pri;
      step();
   endtask

   task automatic word(input logic [11:0] a_in, input logic [15:0] e,
                       input logic emit, input logic [11:0] ea);
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      sg_if.transfering = 1'b1;
      sg_if.data_in     = d;
      sg_if.address_in  = a_in;
      sg_if.eop         = e;
      if (emit) exp_q.push_back('{ea, d});
      step();
   endtask

   task automatic chk_tags(input logic [2:0] pri, input logic [3:0] des);
      chk("wr_priority", {61'd0, sg_if.wr_priority}, {61'd0, pri});
      chk("des_port", {60'd0, sg_if.des_port}, {60'd0, des});
   endtask

   initial begin
      checks = 0;
      errors = 0;

      phase = "reset";
      rst                = 1'b0;
      sg_if.busy         = 1'($urandom());
      sg_if.transfering  = 1'($urandom());
      sg_if.eop          = 16'($urandom());
      sg_if.data_in      = {$urandom(), $urandom()};
      sg_if.address_in   = 12'($urandom());
      sg_if.priority_in  = 3'($urandom());
      sg_if.des_port_in  = 4'($urandom());
      step();
      chk_tags(3'd0, 4'd0);
      chk("address_write", {52'd0, sg_if.address_write}, 64'd0);
      chk("data_write", sg_if.data_write, 64'd0);
      rst = 1'b1;
      idle_in(1'b0);
      step();

      phase = "normal";
      header(3'd6, 4'd9);
      chk_tags(3'd6, 4'd9);
      word(12'h524, 16'h0000, 1'b1, 12'h524);
      for (int i = 1; i < 4; i++) word(12'($urandom()), 16'h0000, 1'b1, 12'h524 + 12'(i));
      word(12'($urandom()), 16'h0020, 1'b1, 12'h528);
      chk_tags(3'd6, 4'd9);
      idle_in(1'b1);
      step();
      step();

      phase = "wrap";
      header(3'd3, 4'd5);
      chk_tags(3'd3, 4'd5);
      word(12'hFFE, 16'h0000, 1'b1, 12'hFFE);
      word(12'h010, 16'h0000, 1'b1, 12'hFFF);
      word(12'h020, 16'h0000, 1'b1, 12'h000);
      word(12'h030, 16'h8000, 1'b1, 12'h001);
      idle_in(1'b0);
      step();
      step();

      phase = "abort";
      header(3'd1, 4'd2);
      word(12'h100, 16'h0000, 1'b1, 12'h100);
      word(12'h000, 16'h0000, 1'b1, 12'h101);
      idle_in(1'b0);
      step();
      sg_if.busy = 1'b0;
      word(12'h100, 16'h0000, 1'b0, 12'h000);
      word(12'h100, 16'h0000, 1'b0, 12'h000);
      idle_in(1'b0);
      step();

      phase = "hold_eop";
      header(3'd4, 4'd7);
      word(12'h200, 16'h0000, 1'b1, 12'h200);
      word(12'h000, 16'h0001, 1'b1, 12'h201);
      for (int i = 0; i < 3; i++) word(12'($urandom()), 16'($urandom()), 1'b0, 12'h000);
      idle_in(1'b1);
      step();
      sg_if.transfering = 1'b1;
      sg_if.des_port_in = 4'd11;
      step();
      chk_tags(3'd4, 4'd11);
      word(12'h300, 16'h0400, 1'b1, 12'h300);
      idle_in(1'b0);
      step();

      phase = "reset_mid";
      header(3'd5, 4'd13);
      chk_tags(3'd5, 4'd13);
      word(12'h400, 16'h0000, 1'b1, 12'h400);
      word(12'h000, 16'h0000, 1'b1, 12'h401);
      rst = 1'b0;
      word(12'h000, 16'h0000, 1'b0, 12'h000);
      chk_tags(3'd0, 4'd0);
      chk("address_write", {52'd0, sg_if.address_write}, 64'd0);
      chk("data_write", sg_if.data_write, 64'd0);
      rst = 1'b1;
      word(12'h000, 16'h0000, 1'b0, 12'h000);
      word(12'h000, 16'h0000, 1'b0, 12'h000);
      idle_in(1'b0);
      step();

      phase = "recover";
      header(3'd2, 4'd14);
      word(12'h7F0, 16'h0100, 1'b1, 12'h7F0);
      chk_tags(3'd2, 4'd14);
      idle_in(1'b0);
      step();

      phase = "end";
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
